adc0809_scan_ctrl: RTL and testbench
====================================

Name: adc0809_scan_ctrl

Overview:
Round-robin scan controller for an external ADC0809 8-channel, 8-bit converter. It walks the enabled channels and drives the address, ALE, START and OE sequence. It tracks the EOC handshake with a timeout, captures each conversion into a per-channel result register file, and emits a one-cycle sample strobe. It sits between the ADC pins and the display/processing logic and is the single owner of the converter.

Parameters:
EOC_TIMEOUT, 255, cycles allowed in each EOC wait phase before abort; 8-bit counter, legal 2..255
OE_CYCLES, 2, cycles OE is held high before data capture, legal 1..4

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  scan enable; sampled only in IDLE and NEXT
CH_EN  input  8  channel enable mask, bit i = channel i
D  input  8  ADC0809 data bus
EOC  input  1  ADC0809 end-of-conversion, externally synchronised
ALE  output  1  address latch enable
START  output  1  conversion start
OE  output  1  ADC output enable
ADDR  output  3  channel address (ADDC,ADDB,ADDA)
RD_SEL  input  3  result register read select
RD_DATA  output  8  result register for RD_SEL, combinational read
SAMPLE_VLD  output  1  one-cycle strobe, new result stored
SAMPLE_CH  output  3  channel of the current strobe
SAMPLE_DATA  output  8  data of the current strobe
BUSY  output  1  high whenever state is not IDLE
TIMEOUT_ERR  output  1  sticky, set on EOC timeout, cleared by reset only

Behaviour:
- Reset: state IDLE. ALE, START, OE, SAMPLE_VLD, BUSY and TIMEOUT_ERR are 0. ADDR=0, SAMPLE_CH=0, SAMPLE_DATA=0, all 8 result registers 0x00, internal channel pointer 0.
- States: IDLE, SEL, STRT, WLO, WHI, READ, STORE, NEXT.
- IDLE: if EN=1 and CH_EN!=0, load the pointer with the lowest enabled channel at or above the current pointer, with wrap. Go to SEL. Otherwise stay in IDLE.
- SEL (1 cycle): ADDR=pointer, ALE=1. Go to STRT.
- STRT (1 cycle): ADDR held, ALE=1, START=1. Go to WLO; timeout counter cleared.
- WLO: wait for EOC=0 (converter acknowledges start).
  - EOC=0 -> WHI, counter cleared.
  - Counter reaches EOC_TIMEOUT -> set TIMEOUT_ERR, go to NEXT with no store.
- WHI: wait for EOC=1.
  - EOC=1 -> READ.
  - Counter reaches EOC_TIMEOUT -> set TIMEOUT_ERR, go to NEXT.
- READ: OE=1 for OE_CYCLES cycles. D is captured on the last READ cycle.
- STORE (1 cycle): OE=1, write the captured byte to result[pointer]. SAMPLE_VLD=1, SAMPLE_CH=pointer, SAMPLE_DATA=byte.
- NEXT (1 cycle): advance the pointer to the next enabled channel above it, wrapping 7->0.
  - If EN=1 and CH_EN!=0 -> SEL; otherwise -> IDLE.
  - With a single enabled channel the pointer stays on that channel.
- CH_EN changes mid-conversion: the current conversion completes. The new mask is used at the next NEXT.
- EN dropped mid-conversion: the current conversion completes and stores. Return to IDLE at NEXT.
- ADDR is held stable from SEL through STORE.
- SAMPLE_VLD is never high for two consecutive cycles.
- Minimum period per sample = 4 + OE_CYCLES + EOC wait cycles.
- Result register write and an RD_SEL read of the same channel in the same cycle: RD_DATA shows the old value that cycle and the new value the next cycle.
- RST_N asserted mid-operation: immediate return to reset values. No partial store.

Optional Feature:
ADC_AVG_EN. When defined, STORE writes (result[pointer] + byte) >> 1 using a 9-bit sum, truncated. SAMPLE_DATA carries the averaged value. The first sample after reset per channel is stored raw; a per-channel valid bit tracks this. When undefined, the raw byte is stored and there is no valid-bit logic.

Test Plan:
- CH_EN=0x05, EN=1, ADC model returns 0x10+ch, EOC low 3 cycles after START, high after 10 -> strobes ch0=0x10, ch2=0x12, ch0, ... ADDR sequence 0,2,0. RD_DATA(2)=0x12.
- CH_EN=0x80 single channel, D=0xA5 -> repeated SAMPLE_CH=7, SAMPLE_DATA=0xA5. The pointer never leaves 7.
- EOC stuck high after START, EOC_TIMEOUT=16 -> TIMEOUT_ERR=1 after 16 cycles in WLO. No SAMPLE_VLD; the scan continues to the next channel.
- EN deasserted during WHI -> one final strobe, then BUSY=0 and IDLE. ALE and START stay 0 afterwards.
- RST_N pulsed low during READ -> all outputs return to reset values at once. Result registers read 0x00.
- ADC_AVG_EN defined, ch1 returns 0x40 then 0x81 -> stored values 0x40 then 0x60.

Source files
------------

// File: rtl/adc0809_scan_ctrl_if.sv
// Pin and result-port bundle for the ADC0809 scan controller.
// master = the controller; slave = converter/consumer side.
interface adc0809_scan_ctrl_if;
    logic       EN;
    logic [7:0] CH_EN;
    logic [7:0] D;
    logic       EOC;
    logic       ALE;
    logic       START;
    logic       OE;
    logic [2:0] ADDR;
    logic [2:0] RD_SEL;
    logic [7:0] RD_DATA;
    logic       SAMPLE_VLD;
    logic [2:0] SAMPLE_CH;
    logic [7:0] SAMPLE_DATA;
    logic       BUSY;
    logic       TIMEOUT_ERR;

    modport master (
        input  EN,
        input  CH_EN,
        input  D,
        input  EOC,
        input  RD_SEL,
        output ALE,
        output START,
        output OE,
        output ADDR,
        output RD_DATA,
        output SAMPLE_VLD,
        output SAMPLE_CH,
        output SAMPLE_DATA,
        output BUSY,
        output TIMEOUT_ERR
    );

    modport slave (
        output EN,
        output CH_EN,
        output D,
        output EOC,
        output RD_SEL,
        input  ALE,
        input  START,
        input  OE,
        input  ADDR,
        input  RD_DATA,
        input  SAMPLE_VLD,
        input  SAMPLE_CH,
        input  SAMPLE_DATA,
        input  BUSY,
        input  TIMEOUT_ERR
    );
endinterface

// File: rtl/adc0809_scan_ctrl.sv
// Round-robin ADC0809 scan controller with EOC timeout and result file.
// Optional macro ADC_AVG_EN: store running 2-point average per channel.
module adc0809_scan_ctrl #(
    parameter int unsigned EOC_TIMEOUT = 255,
    parameter int unsigned OE_CYCLES   = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    adc0809_scan_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_STRT,
        S_WLO,
        S_WHI,
        S_READ,
        S_STORE,
        S_NEXT
    } state_t;

    localparam logic [7:0] LP_TO_LAST = 8'(EOC_TIMEOUT - 1);
    localparam logic [7:0] LP_OE_LAST = 8'(OE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_terr;
    logic       w_terr_nxt;
    logic       w_capture;
    logic [7:0] r_res [8];
    logic [2:0] r_samp_ch;
    logic [7:0] r_samp_data;
    logic [7:0] w_store_val;
    logic       w_go;
    logic [2:0] w_pick_ge;
    logic [2:0] w_pick_gt;

    // First enabled channel at base+offset; excl skips base until last.
    function automatic logic [2:0] f_pick(
        input logic [7:0] mask,
        input logic [2:0] base,
        input logic       incl
    );
        logic [2:0] idx;
        logic [2:0] sel;
        sel = base;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k) + {2'b00, ~incl};
            if (mask[idx]) sel = idx;
        end
        return sel;
    endfunction

    assign w_go      = bus.EN && (bus.CH_EN != 8'h00);
    assign w_pick_ge = f_pick(bus.CH_EN, r_ptr, 1'b1);
    assign w_pick_gt = f_pick(bus.CH_EN, r_ptr, 1'b0);

`ifdef ADC_AVG_EN
    logic [7:0] r_vld;
    logic [8:0] w_sum;

    assign w_sum = {1'b0, r_res[r_ptr]} + {1'b0, bus.D};
    assign w_store_val = r_vld[r_ptr] ? w_sum[8:1] : bus.D;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld <= 8'h00;
        end else if (r_state == S_STORE) begin
            r_vld[r_ptr] <= 1'b1;
        end
    end
`else
    assign w_store_val = bus.D;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_terr_nxt  = r_terr;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_ptr_nxt   = w_pick_ge;
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                w_state_nxt = S_STRT;
            end
            S_STRT: begin
                w_cnt_nxt   = 8'h00;
                w_state_nxt = S_WLO;
            end
            S_WLO: begin
                if (!bus.EOC) begin
                    w_cnt_nxt   = 8'h00;
                    w_state_nxt = S_WHI;
                end else if (r_cnt == LP_TO_LAST) begin
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'h01;
                end
            end
            S_WHI: begin
                if (bus.EOC) begin
                    w_cnt_nxt   = 8'h00;
                    w_state_nxt = S_READ;
                end else if (r_cnt == LP_TO_LAST) begin
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'h01;
                end
            end
            S_READ: begin
                if (r_cnt == LP_OE_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_STORE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'h01;
                end
            end
            S_STORE: begin
                w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                w_ptr_nxt   = w_pick_gt;
                w_state_nxt = w_go ? S_SEL : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_cnt       <= 8'h00;
            r_terr      <= 1'b0;
            r_samp_ch   <= 3'd0;
            r_samp_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_terr  <= w_terr_nxt;
            if (w_capture) begin
                r_samp_ch   <= r_ptr;
                r_samp_data <= w_store_val;
            end
        end
    end

    // Written at the end of STORE so a same-cycle read sees the old value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) begin
                r_res[i] <= 8'h00;
            end
        end else if (r_state == S_STORE) begin
            r_res[r_ptr] <= r_samp_data;
        end
    end

    assign bus.ALE = (r_state == S_SEL) ||
                     (r_state == S_STRT);
    assign bus.START = (r_state == S_STRT);
    assign bus.OE = (r_state == S_READ) ||
                    (r_state == S_STORE);
    assign bus.ADDR        = r_ptr;
    assign bus.RD_DATA     = r_res[bus.RD_SEL];
    assign bus.SAMPLE_VLD  = (r_state == S_STORE);
    assign bus.SAMPLE_CH   = r_samp_ch;
    assign bus.SAMPLE_DATA = r_samp_data;
    assign bus.BUSY        = (r_state != S_IDLE);
    assign bus.TIMEOUT_ERR = r_terr;

endmodule

// File: tb/tb_adc0809_scan_ctrl.sv
// Randomised bench for adc0809_scan_ctrl against a timing-formula model.
// Conversion windows are derived from chosen EOC delays, not from states.
module tb_adc0809_scan_ctrl;

    localparam int T   = 16;
    localparam int OEC = 2;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    adc0809_scan_ctrl_if bus();

    adc0809_scan_ctrl #(
        .EOC_TIMEOUT(T),
        .OE_CYCLES  (OEC)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    bit         m_busy;
    int         m_sel;
    int         m_L;
    int         m_H;
    logic [7:0] m_d;
    logic [2:0] m_ch;
    logic [2:0] m_ptr;
    logic [7:0] m_res [8];
    bit         m_terr;
`ifdef ADC_AVG_EN
    bit         m_vld [8];
`endif
    bit         prev_vld;

    bit         nxt_en;
    logic [7:0] nxt_mask;
    int         rd_force = -1;
    int         fix_L    = -1;
    int         fix_H    = -1;
    int         d_mode   = 0;
    logic [7:0] d_const  = 8'h00;
    logic [7:0] d_q [$];

    logic [2:0] log_ch [$];
    logic [7:0] log_d [$];
    int         log_cyc [$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] pick(input logic [7:0] mask,
                                        input logic [2:0] base,
                                        input bit incl);
        int idx;
        for (int k = 0; k < 8; k++) begin
            idx = (int'(base) + k + (incl ? 0 : 1)) % 8;
            if (mask[idx]) return 3'(idx);
        end
        return base;
    endfunction

    function automatic bit f_done();
        return (m_L < T) && (m_H <= T);
    endfunction

    function automatic int f_ostore();
        return m_L + m_H + 3 + OEC;
    endfunction

    function automatic int f_onext();
        if (f_done()) return f_ostore() + 1;
        if (m_L >= T) return T + 2;
        return m_L + T + 3;
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_ptr    = 3'd0;
        m_terr   = 0;
        prev_vld = 0;
        for (int i = 0; i < 8; i++) begin
            m_res[i] = 8'h00;
`ifdef ADC_AVG_EN
            m_vld[i] = 0;
`endif
        end
    endtask

    task automatic new_conv();
        int r;
        m_busy = 1;
        m_sel  = cyc + 1;
        m_ch   = m_ptr;
        r   = $urandom_range(0, 9);
        m_L = $urandom_range(0, 4);
        m_H = $urandom_range(1, 6);
        if (r == 0) m_L = T;
        if (r == 1) m_L = T - 1;
        if (r == 2) m_H = T + 1;
        if (r == 3) m_H = T;
        if (fix_L >= 0) m_L = fix_L;
        if (fix_H >= 0) m_H = fix_H;
        if (d_q.size() > 0) m_d = d_q.pop_front();
        else if (d_mode == 1) m_d = 8'h10 + {5'd0, m_ch};
        else if (d_mode == 2) m_d = d_const;
        else m_d = 8'($urandom);
    endtask

    task automatic step();
        int o;
        int k;
        bit ale_e;
        bit st_e;
        bit oe_e;
        bit vld_e;
        logic [7:0] exp_v;
        logic [8:0] s;
        @(negedge CLK);
        o     = cyc - m_sel;
        ale_e = 0;
        st_e  = 0;
        oe_e  = 0;
        vld_e = 0;
        s     = 9'd0;
        exp_v = m_d;
`ifdef ADC_AVG_EN
        if (m_vld[m_ch]) begin
            s = {1'b0, m_res[m_ch]} + {1'b0, m_d};
            exp_v = s[8:1];
        end
`endif
        if (m_busy) begin
            ale_e = (o <= 1);
            st_e  = (o == 1);
            if (f_done()) begin
                oe_e  = (o >= f_ostore() - OEC) && (o <= f_ostore());
                vld_e = (o == f_ostore());
            end else if (o == f_onext()) begin
                m_terr = 1;
            end
        end
        chk("BUSY", bus.BUSY, m_busy);
        chk("ALE", bus.ALE, ale_e);
        chk("START", bus.START, st_e);
        chk("OE", bus.OE, oe_e);
        chk("SAMPLE_VLD", bus.SAMPLE_VLD, vld_e);
        chk("ADDR", bus.ADDR, m_ptr);
        chk("TIMEOUT_ERR", bus.TIMEOUT_ERR, m_terr);
        chk("RD_DATA", bus.RD_DATA, m_res[bus.RD_SEL]);
        chk("VLD_BACK2BACK", bus.SAMPLE_VLD & prev_vld, 0);
        if (vld_e) begin
            chk("SAMPLE_CH", bus.SAMPLE_CH, m_ch);
            chk("SAMPLE_DATA", bus.SAMPLE_DATA, exp_v);
            m_res[m_ch] = exp_v;
`ifdef ADC_AVG_EN
            m_vld[m_ch] = 1;
`endif
        end
        if (bus.SAMPLE_VLD) begin
            log_ch.push_back(bus.SAMPLE_CH);
            log_d.push_back(bus.SAMPLE_DATA);
            log_cyc.push_back(cyc);
        end
        prev_vld = bus.SAMPLE_VLD;
        // Pins for the edge that closes this cycle.
        bus.EN    = nxt_en;
        bus.CH_EN = nxt_mask;
        if (rd_force >= 0) bus.RD_SEL = 3'(rd_force);
        else bus.RD_SEL = 3'($urandom_range(0, 7));
        k = o - 1;
        bus.EOC = 1'b1;
        if (m_busy && k >= m_L + 1 && k <= m_L + m_H) bus.EOC = 1'b0;
        bus.D = 8'($urandom);
        if (m_busy && f_done() && o == f_ostore() - 1) bus.D = m_d;
        if (RST_N) begin
            if (m_busy && o == f_onext()) begin
                m_ptr = pick(nxt_mask, m_ptr, 0);
                if (nxt_en && nxt_mask != 0) new_conv();
                else m_busy = 0;
            end else if (!m_busy && nxt_en && nxt_mask != 0) begin
                m_ptr = pick(nxt_mask, m_ptr, 1);
                new_conv();
            end
        end
    endtask

    task automatic run_strobes(input int n, input int budget);
        int i = 0;
        while (log_d.size() < n && i < budget) begin
            step();
            i++;
        end
        chk("strobe_wait", int'(log_d.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (m_busy && i < budget) begin
            step();
            i++;
        end
        step();
        chk("idle_wait", int'(i < budget), 1);
        chk("idle_busy", bus.BUSY, 0);
    endtask

    task automatic wait_ale(input int budget);
        int i = 0;
        while (!bus.ALE && i < budget) begin
            step();
            i++;
        end
        chk("ale_wait", int'(i < budget), 1);
    endtask

    initial begin
        int i;
        int t0;
        bus.EN     = 1'b0;
        bus.CH_EN  = 8'h00;
        bus.D      = 8'h00;
        bus.EOC    = 1'b1;
        bus.RD_SEL = 3'd0;
        nxt_en     = 0;
        nxt_mask   = 8'h00;
        model_reset();
        repeat (3) step();
        RST_N = 1'b1;
        step();

        // Two-channel scan with fixed EOC timing.
        d_mode   = 1;
        fix_L    = 2;
        fix_H    = 7;
        nxt_mask = 8'h05;
        nxt_en   = 1;
        log_ch.delete(); log_d.delete(); log_cyc.delete();
        run_strobes(3, 200);
        if (log_d.size() >= 3) begin
            chk("t1_ch0", log_ch[0], 3'd0);
            chk("t1_ch1", log_ch[1], 3'd2);
            chk("t1_ch2", log_ch[2], 3'd0);
            chk("t1_d0", log_d[0], 8'h10);
            chk("t1_d1", log_d[1], 8'h12);
            chk("t1_d2", log_d[2], 8'h10);
            chk("t1_period", log_cyc[1] - log_cyc[0], 16);
        end
        nxt_en = 0;
        wait_idle(100);
        rd_force = 2;
        step();
        #1 chk("t1_rd2", bus.RD_DATA, 8'h12);
        rd_force = -1;

        // Single channel: pointer pinned to 7.
        d_mode   = 2;
        d_const  = 8'hA5;
        fix_L    = 1;
        fix_H    = 2;
        nxt_mask = 8'h80;
        nxt_en   = 1;
        log_ch.delete(); log_d.delete(); log_cyc.delete();
        run_strobes(3, 200);
        for (int j = 0; j < 3 && j < log_d.size(); j++) begin
            chk("t2_ch", log_ch[j], 3'd7);
            chk("t2_d", log_d[j], 8'hA5);
        end
        chk("t2_addr", bus.ADDR, 3'd7);
        nxt_en = 0;
        wait_idle(100);

        // EOC never falls: timeout, then scan moves to channel 1.
        fix_L    = 1000;
        nxt_mask = 8'h03;
        nxt_en   = 1;
        log_d.delete(); log_ch.delete(); log_cyc.delete();
        step();
        wait_ale(20);
        t0 = cyc;
        i  = 0;
        while (!bus.TIMEOUT_ERR && i < 100) begin
            step();
            i++;
        end
        chk("t3_terr", bus.TIMEOUT_ERR, 1);
        chk("t3_when", cyc - t0, T + 2);
        chk("t3_nostrobe", log_d.size(), 0);
        step();
        wait_ale(20);
        chk("t3_addr", bus.ADDR, 3'd1);
        nxt_en = 0;
        wait_idle(100);
        fix_L = -1;

        // EN dropped while waiting for EOC high.
        fix_L    = 1;
        fix_H    = 8;
        d_mode   = 0;
        nxt_mask = 8'h0F;
        nxt_en   = 1;
        i = 0;
        while (!(m_busy && cyc - m_sel == m_L + 4) && i < 100) begin
            step();
            i++;
        end
        chk("t4_reach", int'(i < 100), 1);
        nxt_en = 0;
        log_d.delete(); log_ch.delete(); log_cyc.delete();
        repeat (40) step();
        chk("t4_one", log_d.size(), 1);
        chk("t4_busy", bus.BUSY, 0);

        // Reset asserted during READ.
        fix_L  = 1;
        fix_H  = 3;
        nxt_en = 1;
        i = 0;
        while (!(m_busy && f_done() &&
                 cyc - m_sel == f_ostore() - 1) && i < 100) begin
            step();
            i++;
        end
        chk("t5_reach", int'(i < 100), 1);
        nxt_en = 0;
        bus.EN = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        chk("t5_ale", bus.ALE, 0);
        chk("t5_start", bus.START, 0);
        chk("t5_oe", bus.OE, 0);
        chk("t5_vld", bus.SAMPLE_VLD, 0);
        chk("t5_busy", bus.BUSY, 0);
        chk("t5_terr", bus.TIMEOUT_ERR, 0);
        chk("t5_addr", bus.ADDR, 0);
        chk("t5_sch", bus.SAMPLE_CH, 0);
        chk("t5_sdata", bus.SAMPLE_DATA, 0);
        for (int j = 0; j < 8; j++) begin
            bus.RD_SEL = 3'(j);
            #1 chk("t5_rd", bus.RD_DATA, 8'h00);
        end
        model_reset();
        repeat (2) step();
        RST_N = 1'b1;
        step();

`ifdef ADC_AVG_EN
        // Averaging: raw first sample, then (old + new) >> 1.
        d_q.push_back(8'h40);
        d_q.push_back(8'h81);
        nxt_mask = 8'h02;
        nxt_en   = 1;
        log_d.delete(); log_ch.delete(); log_cyc.delete();
        run_strobes(2, 200);
        nxt_en = 0;
        if (log_d.size() >= 2) begin
            chk("t6_d0", log_d[0], 8'h40);
            chk("t6_d1", log_d[1], 8'h60);
        end
        wait_idle(100);
        rd_force = 1;
        step();
        #1 chk("t6_rd1", bus.RD_DATA, 8'h60);
        rd_force = -1;
        d_q.delete();
`endif

        // Random traffic: masks and EN wander, EOC timing random.
        fix_L    = -1;
        fix_H    = -1;
        d_mode   = 0;
        nxt_en   = 1;
        nxt_mask = 8'h5A;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0)
                nxt_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 59) == 0) begin
                nxt_mask = 8'($urandom);
                if ($urandom_range(0, 7) == 0) nxt_mask = 8'h00;
            end
            step();
        end
        nxt_en = 0;
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
